mc_datapath_gen: RTL and testbench
==================================

// Module: mc_datapath_gen
// PURPOSE
//  Parametrised multicycle datapath, successor of the fixed 32-bit multicycle datapath. Holds PC, IR, memory-data,
//  A, WriteData, ALUOut and NZCV flag registers, plus an internal register file, extender and ALU. It is driven
//  cycle by cycle by the multicycle controller FSM. New over the previous generation:
//  - WIDTH/NREGS generalisation
//  - memory wait-state handshake (MemReady)
//  - architectural flag register with split FlagWrite
//  - 5-op ALU
// PARAMETERS
//  WIDTH     32  datapath width, >=32
//  NREGS     16  register count, power of 2; index NREGS-1 is the PC alias
//  PC_STEP   4   increment used by ALUSrcB=10 and by PC-alias reads
//  RESET_PC  0   PC value after reset
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-low; 0 clears all state
//  MemReady    in   1      1 = memory cycle complete; 0 = stall, all state holds
//  ReadData    in   WIDTH  memory read data
//  Adr         out  WIDTH  memory address
//  WriteData   out  WIDTH  registered RD2, memory store data
//  Instr       out  WIDTH  instruction register
//  ALUFlags    out  4      combinational NZCV of the current ALU op
//  Flags       out  4      registered NZCV
//  PCWrite     in   1      load PC with Result
//  IRWrite     in   1      load IR with ReadData
//  RegWrite    in   1      write Result to R[Instr[15:12]]
//  FlagWrite   in   2      [1] update N,Z; [0] update C,V
//  AdrSrc      in   1      0 = PC, 1 = Result
//  RegSrc      in   2      [0] RA1 = NREGS-1, else Instr[19:16]; [1] RA2 = Instr[15:12], else Instr[3:0]
//  ALUSrcA     in   2      00 A, 01 PC, 1x zero
//  ALUSrcB     in   2      00 WriteData, 01 ExtImm, 10 PC_STEP, 11 zero
//  ResultSrc   in   2      00 ALUOut, 01 Data, 1x ALUResult
//  ImmSrc      in   2      00 zext Instr[7:0]; 01 zext Instr[11:0]; 10 sext {Instr[23:0],2'b00}; 11 zero
//  ALUControl  in   3      000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, others result 0
// BEHAVIOUR
//  Reset (async, reset==0):
//   - PC=RESET_PC; IR, Data, A, WriteData, ALUOut, Flags and all NREGS registers = 0.
//   - Applies mid-operation; no partial update survives.
//  Register updates (every rising edge when MemReady==1 and reset==1):
//   - Data<=ReadData; A<=RD1; WriteData<=RD2; ALUOut<=ALUResult (unconditional).
//   - PC<=Result if PCWrite; IR<=ReadData if IRWrite.
//   - Register file written if RegWrite; Flags fields written per FlagWrite.
//  Stall: MemReady==0 blocks every register/regfile/flag update, including enabled ones.
//   - Combinational outputs (Adr, ALUFlags) keep following the held state.
//  Register file:
//   - Reads are combinational.
//   - A read of index NREGS-1 returns PC+PC_STEP (PC+8 of the fetched instr once the fetch has bumped PC).
//   - Writes to index NREGS-1 are ignored; PC changes only via PCWrite.
//   - Same-cycle write and read of one index: read returns the old value.
//  Latency: register paths 1 cycle; Adr/ALUFlags/Result 0 cycles. All adds wrap mod 2^WIDTH.
//  ALU flags:
//   - N = res[WIDTH-1]; Z = (res==0).
//   - ADD: C = carry out. SUB: computed as A+~B+1, C = carry out (1 = no borrow).
//   - V = signed overflow for ADD/SUB.
//   - AND/ORR/EOR/undefined: C=V=0.
//  Sign extension of the branch immediate fills to WIDTH.
// TESTING
//  1. Reset: reset=0 then 1 with RESET_PC=0x100 -> PC=0x100, Adr=0x100, Instr=0, Flags=0, all regs read 0.
//  2. Fetch: ReadData=0xE2811005, IRWrite=PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10
//     -> next cycle Instr=0xE2811005, PC=0x104.
//  3. Stall: as test 2 but MemReady=0 for 3 cycles -> PC, Instr unchanged for 3 cycles; update on the cycle MemReady=1.
//  4. ALU/flags: A=0x7FFFFFFF, WriteData=1, ADD, FlagWrite=11 -> ALUResult=0x80000000, Flags NZCV=1001;
//     SUB with equal operands -> NZCV=0110.
//  5. PC alias: PC=0x104, RegSrc[0]=1 -> A=0x108 next cycle;
//     RegWrite to index 15 -> no change, PC unchanged.
//  6. Reset mid-op: assert reset during an enabled RegWrite/PCWrite cycle -> all state 0 / RESET_PC immediately, write lost.

Source files
------------

// File: rtl/mc_datapath_gen.sv
// mc_datapath_gen: parametrised multicycle datapath with stall handshake, NZCV flag register and 5-op ALU
module mc_datapath_gen #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter logic [WIDTH-1:0] PC_STEP = WIDTH'(4),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemReady,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Instr,
  output logic [3:0]       ALUFlags,
  output logic [3:0]       Flags,
  input  logic             PCWrite,
  input  logic             IRWrite,
  input  logic             RegWrite,
  input  logic [1:0]       FlagWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [2:0]       ALUControl
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  logic [WIDTH-1:0] pc, ir, data, a, wd, alu_out;
  logic [3:0] flags;
  logic [WIDTH-1:0] rf [NREGS];
  logic [AW-1:0] ra1, ra2, wa;
  logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, b_eff, alu_res, result;
  logic [WIDTH:0] sum;
  logic sub, arith, ovf;
  // Register-file addressing, PC-alias reads and operand selection
  always_comb begin
    ra1 = RegSrc[0] ? LAST : ir[16 +: AW];
    ra2 = RegSrc[1] ? ir[12 +: AW] : ir[0 +: AW];
    wa = ir[12 +: AW];
    rd1 = (ra1 == LAST) ? pc + PC_STEP : rf[ra1];
    rd2 = (ra2 == LAST) ? pc + PC_STEP : rf[ra2];
    ext_imm = ImmSrc == 2'b00 ? {{(WIDTH-8){1'b0}}, ir[7:0]} :
              ImmSrc == 2'b01 ? {{(WIDTH-12){1'b0}}, ir[11:0]} :
              ImmSrc == 2'b10 ? {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00} : '0;
    src_a = ALUSrcA[1] ? '0 : ALUSrcA[0] ? pc : a;
    src_b = ALUSrcB == 2'b00 ? wd : ALUSrcB == 2'b01 ? ext_imm :
            ALUSrcB == 2'b10 ? PC_STEP : '0;
  end
  // ALU: SUB is A + ~B + 1 so carry out means "no borrow"
  always_comb begin
    sub = ALUControl == 3'b001;
    arith = ALUControl[2:1] == 2'b00;
    b_eff = sub ? ~src_b : src_b;
    sum = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    ovf = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    alu_res = arith ? sum[WIDTH-1:0] :
              ALUControl == 3'b010 ? src_a & src_b :
              ALUControl == 3'b011 ? src_a | src_b :
              ALUControl == 3'b100 ? src_a ^ src_b : '0;
    ALUFlags = {alu_res[WIDTH-1], alu_res == '0, arith & sum[WIDTH], arith & ovf};
    result = ResultSrc[1] ? alu_res : ResultSrc[0] ? data : alu_out;
    Adr = AdrSrc ? result : pc;
  end
  assign Instr = ir;
  assign WriteData = wd;
  assign Flags = flags;
  // Architectural and pipeline registers; a low MemReady freezes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      ir <= '0;
      data <= '0;
      a <= '0;
      wd <= '0;
      alu_out <= '0;
      flags <= '0;
    end else if (MemReady) begin
      data <= ReadData;
      a <= rd1;
      wd <= rd2;
      alu_out <= alu_res;
      if (PCWrite) pc <= result;
      if (IRWrite) ir <= ReadData;
      if (FlagWrite[1]) flags[3:2] <= ALUFlags[3:2];
      if (FlagWrite[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end
  // Register file; the PC-alias slot is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (MemReady && RegWrite && wa != LAST) begin
      rf[wa] <= result;
    end
  end
endmodule

// File: tb/tb_mc_datapath_gen.sv
// tb_mc_datapath_gen: directed self-checking bench for mc_datapath_gen
module tb_mc_datapath_gen;
  logic clk = 0, reset = 0, MemReady = 1;
  logic [31:0] ReadData = '0, Adr, WriteData, Instr;
  logic [3:0] ALUFlags, Flags;
  logic PCWrite, IRWrite, RegWrite, AdrSrc;
  logic [1:0] FlagWrite, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  int checks = 0, errors = 0;

  mc_datapath_gen #(.WIDTH(32), .NREGS(16), .PC_STEP(32'd4), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .MemReady(MemReady), .ReadData(ReadData), .Adr(Adr),
    .WriteData(WriteData), .Instr(Instr), .ALUFlags(ALUFlags), .Flags(Flags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .FlagWrite(FlagWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    PCWrite = 0; IRWrite = 0; RegWrite = 0; FlagWrite = 0; AdrSrc = 0; RegSrc = 0;
    ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0; MemReady = 1;
  endtask

  task automatic show_a();
    idle(); AdrSrc = 1; ResultSrc = 2'b10; ALUSrcA = 2'b00; ALUSrcB = 2'b11;
    #1;
  endtask

  task automatic show_wd();
    idle(); AdrSrc = 1; ResultSrc = 2'b10; ALUSrcA = 2'b10; ALUSrcB = 2'b00;
    #1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    idle(); ReadData = v; IRWrite = 1;
    tick();
    idle();
  endtask

  task automatic write_rd(input logic [31:0] v);
    idle(); ReadData = v;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    idle();
  endtask

  task automatic fetch(input logic [31:0] v);
    idle(); ReadData = v; IRWrite = 1; PCWrite = 1;
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
  endtask

  initial begin
    idle();
    #12 reset = 1;
    chk("reset_pc", Adr, 32'h100);
    chk("reset_ir", Instr, 0);
    chk("reset_flags", {28'd0, Flags}, 0);
    show_a();
    chk("reset_a", Adr, 0);
    chk("reset_aluflags", {28'd0, ALUFlags}, 32'h4);
    fetch(32'hE2811005);
    #1;
    chk("fetch_adr_pre", Adr, 32'h100);
    tick();
    idle();
    #1;
    chk("fetch_ir", Instr, 32'hE2811005);
    chk("fetch_pc", Adr, 32'h104);
    fetch(32'hE3A0200A);
    MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ir", Instr, 32'hE2811005);
      chk("stall_pc", Adr, 32'h104);
    end
    MemReady = 1;
    tick();
    idle();
    #1;
    chk("unstall_ir", Instr, 32'hE3A0200A);
    chk("unstall_pc", Adr, 32'h108);
    load_ir(32'h00001000);
    write_rd(32'h7FFFFFFF);
    load_ir(32'h00002000);
    write_rd(32'h1);
    load_ir(32'h00010002);
    tick();
    idle(); AdrSrc = 1; ResultSrc = 2'b10; FlagWrite = 2'b11;
    #1;
    chk("add_res", Adr, 32'h80000000);
    chk("add_aluflags", {28'd0, ALUFlags}, 32'h9);
    tick();
    chk("add_flags", {28'd0, Flags}, 32'h9);
    FlagWrite = 0; ALUControl = 3'b001;
    #1;
    chk("sub_res", Adr, 32'h7FFFFFFE);
    chk("sub_aluflags", {28'd0, ALUFlags}, 32'h2);
    ALUControl = 3'b010;
    #1;
    chk("and_res", Adr, 32'h1);
    ALUControl = 3'b011;
    #1;
    chk("orr_res", Adr, 32'h7FFFFFFF);
    ALUControl = 3'b100;
    #1;
    chk("eor_res", Adr, 32'h7FFFFFFE);
    chk("eor_aluflags", {28'd0, ALUFlags}, 0);
    ALUControl = 3'b101;
    #1;
    chk("undef_res", Adr, 0);
    chk("undef_aluflags", {28'd0, ALUFlags}, 32'h4);
    load_ir(32'h00020002);
    tick();
    idle(); AdrSrc = 1; ResultSrc = 2'b10; FlagWrite = 2'b11; ALUControl = 3'b001;
    #1;
    chk("subeq_res", Adr, 0);
    chk("subeq_aluflags", {28'd0, ALUFlags}, 32'h6);
    tick();
    chk("subeq_flags", {28'd0, Flags}, 32'h6);
    FlagWrite = 2'b01; ALUControl = 3'b000;
    #1;
    chk("add2_res", Adr, 32'h2);
    tick();
    idle();
    chk("split_flags", {28'd0, Flags}, 32'h4);
    load_ir(32'h00800001);
    AdrSrc = 1; ResultSrc = 2'b10; ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 2'b10;
    #1;
    chk("imm_branch_sext", Adr, 32'hFE000004);
    ImmSrc = 2'b01;
    #1;
    chk("imm_zext12", Adr, 32'h1);
    idle(); RegSrc = 2'b01;
    tick();
    show_a();
    chk("pc_alias_a", Adr, 32'h10C);
    load_ir(32'h0000F000);
    write_rd(32'hDEADBEEF);
    #1;
    chk("r15_write_pc", Adr, 32'h108);
    load_ir(32'h000F0000);
    tick();
    show_a();
    chk("r15_read_alias", Adr, 32'h10C);
    load_ir(32'h00033000);
    ReadData = 32'h55;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    show_a();
    chk("rw_same_old", Adr, 0);
    idle();
    tick();
    show_a();
    chk("rw_same_new", Adr, 32'h55);
    load_ir(32'h00001000);
    ReadData = 32'h12345678;
    tick();
    ResultSrc = 2'b01; RegWrite = 1; PCWrite = 1;
    #2 reset = 0;
    #1;
    chk("midreset_pc", Adr, 32'h100);
    chk("midreset_ir", Instr, 0);
    chk("midreset_flags", {28'd0, Flags}, 0);
    tick();
    idle();
    reset = 1;
    load_ir(32'h00010001);
    tick();
    show_a();
    chk("midreset_r1", Adr, 0);
    show_wd();
    chk("midreset_wd", Adr, 0);
    idle();
    #1;
    chk("midreset_pc_hold", Adr, 32'h100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
